beat_frame_deserializer: RTL



---
 rtl/beat_link_pkg.sv | 19 +
 rtl/beat_shift_reg.sv | 36 +++
 rtl/beat_frame_deserializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/beat_link_pkg.sv
// Shared types for the narrow-beat port link: deserializer state encoding,
// drop counter width and the per-frame status record.
package beat_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD,
        DRAIN
    } deser_state_e;

    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic err;
        logic long_frame;
    } frame_status_t;

endpackage

// File: rtl/beat_shift_reg.sv
// Slice-indexed frame register: beat k lands in slice k, and writing slice 0
// clears every other slice so a new frame never carries stale bytes.
module beat_shift_reg #(
    parameter  int BEAT_W = 8,
    parameter  int BEATS  = 8,
    localparam int IDX_W  = $clog2(BEATS) + 1,
    localparam int WORD_W = BEAT_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [BEAT_W-1:0] wrBeat,
    output logic [WORD_W-1:0] frameWord
);

    logic [WORD_W-1:0] nextWord;

    always_comb begin
        nextWord = (wrIdx == '0) ? '0 : frameWord;
        for (int k = 0; k < BEATS; k++) begin
            if (wrIdx == IDX_W'(k)) begin
                nextWord[k*BEAT_W +: BEAT_W] = wrBeat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frameWord <= '0;
        end else if (wrEn) begin
            frameWord <= nextWord;
        end
    end

endmodule

// File: rtl/beat_frame_deserializer.sv
// Reassembles BEATS narrow beats into one frame, flags short/long framing
// errors and discards the tail of over-long frames while counting drops.
module beat_frame_deserializer
    import beat_link_pkg::*;
#(
    parameter  int BEAT_W = 8,
    parameter  int BEATS  = 8,
    localparam int WORD_W = BEAT_W * BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BEAT_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_W-1:0]     m_data,
    output logic                  m_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int IDX_W = $clog2(BEATS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    deser_state_e          state, stateNext;
    logic [IDX_W-1:0]      beatIdx, beatIdxNext;
    frame_status_t         status, statusNext;
    logic [DROP_CNT_W-1:0] dropCnt, dropCntNext;
    logic                  beatAcc;

    assign s_ready  = (state == COLLECT) || (state == DRAIN);
    assign m_valid  = (state == HOLD);
    assign beatAcc  = s_valid && s_ready;
    assign m_err    = status.err;
    assign drop_cnt = dropCnt;

    beat_shift_reg #(
        .BEAT_W(BEAT_W),
        .BEATS (BEATS)
    ) u_shiftReg (
        .clk      (clk),
        .rst      (rst),
        .wrEn     ((state == COLLECT) && beatAcc),
        .wrIdx    (beatIdx),
        .wrBeat   (s_data),
        .frameWord(m_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beatIdx <= '0;
            status  <= '0;
            dropCnt <= '0;
        end else begin
            state   <= stateNext;
            beatIdx <= beatIdxNext;
            status  <= statusNext;
            dropCnt <= dropCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        beatIdxNext = beatIdx;
        statusNext  = status;
        dropCntNext = dropCnt;
        case (state)
            IDLE: begin
                stateNext = COLLECT;
            end
            COLLECT: begin
                if (beatAcc) begin
                    // A frame closes on s_last or on the final slot, whichever comes first.
                    if (s_last || (beatIdx == LAST_IDX)) begin
                        stateNext             = HOLD;
                        statusNext.err        = !(s_last && (beatIdx == LAST_IDX));
                        statusNext.long_frame = !s_last;
                    end else begin
                        beatIdxNext = beatIdx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    stateNext   = status.long_frame ? DRAIN : COLLECT;
                    beatIdxNext = '0;
                end
            end
            DRAIN: begin
                if (beatAcc) begin
                    if (dropCnt != '1) begin
                        dropCntNext = dropCnt + DROP_CNT_W'(1);
                    end
                    if (s_last) begin
                        stateNext = COLLECT;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Handshake stability obligations on both streams.
    assert property (@(posedge clk) disable iff (rst)
        (s_valid && !s_ready) |=> ($stable(s_data) && $stable(s_last)));

    assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> ($stable(m_data) && $stable(m_err)));

endmodule
